game_fsm_nxn: RTL

- Parametrised successor to the fixed 4x4 debug game FSM: a complete 2048-style game engine for a GRID_N x GRID_N board.
- Supports all four move directions, single-merge-per-tile semantics, pseudo-random tile spawn, score accumulation, win/lose detection and a debug grid-load port.
- Sits between the debounced button/input block and the VGA grid renderer.
- Cells are stored as exponents: 0 = empty, k = tile value 2^k.

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_fsm_nxn_if.sv | 29 ++
 rtl/line_merge.sv | 67 ++++++
 rtl/game_fsm_nxn.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state/direction types and helpers for the 2048 game engine
package game_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_SPAWN0,
        S_SPAWN1,
        S_PLAY,
        S_SHIFT,
        S_SPAWN,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    function automatic int cell_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/game_fsm_nxn_if.sv
// rtl/game_fsm_nxn_if.sv - control/board bundle between input block, game engine and renderer
interface game_fsm_nxn_if #(
    parameter int GRID_N  = 4,
    parameter int EXP_W   = 4,
    parameter int SCORE_W = 20
);
    logic                            start;
    logic                            mov_up;
    logic                            mov_down;
    logic                            mov_left;
    logic                            mov_right;
    logic                            load_en;
    logic [GRID_N*GRID_N*EXP_W-1:0]  load_grid;
    logic [GRID_N*GRID_N*EXP_W-1:0]  grid;
    logic [SCORE_W-1:0]              score;
    logic                            busy;
    logic                            win;
    logic                            lose;

    modport master (
        output start, mov_up, mov_down, mov_left, mov_right, load_en, load_grid,
        input  grid, score, busy, win, lose
    );

    modport slave (
        input  start, mov_up, mov_down, mov_left, mov_right, load_en, load_grid,
        output grid, score, busy, win, lose
    );
endinterface

// File: rtl/line_merge.sv
// rtl/line_merge.sv - combinational compact-and-merge of one board line toward element 0
module line_merge #(
    parameter int GRID_N  = 4,
    parameter int EXP_W   = 4,
    parameter int SCORE_W = 20
) (
    input  logic [GRID_N*EXP_W-1:0] line_in,
    output logic [GRID_N*EXP_W-1:0] line_out,
    output logic [SCORE_W-1:0]      score_inc,
    output logic                    changed
);
    localparam logic [EXP_W-1:0]   EXP_MAX   = '1;
    localparam logic [SCORE_W:0]   ACC_MAX   = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   ACC_ONE   = 1;

    // Extra trailing zero lets the pair compare look one past the end safely
    logic [EXP_W-1:0] comp [GRID_N+1];
    logic [SCORE_W:0] acc;
    logic             skip;
    int               wr;
    int               wo;
    int               p;

    always_comb begin
        for (int k = 0; k <= GRID_N; k++) begin
            comp[k] = '0;
        end
        wr = 0;
        for (int k = 0; k < GRID_N; k++) begin
            if (line_in[k*EXP_W +: EXP_W] != '0) begin
                comp[wr] = line_in[k*EXP_W +: EXP_W];
                wr = wr + 1;
            end
        end
    end

    always_comb begin
        line_out = '0;
        acc      = '0;
        skip     = 1'b0;
        wo       = 0;
        p        = 0;
        for (int k = 0; k < GRID_N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[k] != '0) begin
                if (comp[k+1] == comp[k]) begin
                    line_out[wo*EXP_W +: EXP_W] = (comp[k] == EXP_MAX) ? EXP_MAX : comp[k] + 1'b1;
                    p = int'(comp[k]) + 1;
                    if (p >= SCORE_W) begin
                        acc = ACC_MAX;
                    end else begin
                        acc = acc + (ACC_ONE << p);
                        if (acc[SCORE_W]) acc = ACC_MAX;
                    end
                    skip = 1'b1;
                end else begin
                    line_out[wo*EXP_W +: EXP_W] = comp[k];
                end
                wo = wo + 1;
            end
        end
        score_inc = acc[SCORE_W-1:0];
        changed   = (line_out != line_in);
    end

endmodule

// File: rtl/game_fsm_nxn.sv
// rtl/game_fsm_nxn.sv - 2048-style game engine on a GRID_N x GRID_N board of exponent cells
module game_fsm_nxn
    import game_pkg::*;
#(
    parameter int          GRID_N    = 4,
    parameter int          EXP_W     = 4,
    parameter int          WIN_EXP   = 11,
    parameter int          SCORE_W   = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic           clk,
    input logic           reset,
    game_fsm_nxn_if.slave bus
);
    localparam int NN    = GRID_N * GRID_N;
    localparam int GW    = NN * EXP_W;
    localparam int IDX_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
    localparam logic [IDX_W-1:0]   LAST_LINE = IDX_W'(GRID_N - 1);
    localparam logic [EXP_W-1:0]   WIN_THR   = EXP_W'(WIN_EXP);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d, move_dir;
    logic [GW-1:0]       grid_q, grid_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                changed_q, changed_d;
    logic [IDX_W-1:0]    line_q, line_d;
    logic [15:0]         lfsr_q;

    logic [3:0]              move_vec;
    logic                    move_one;
    int                      pos [GRID_N];
    logic [GRID_N*EXP_W-1:0] line_in, line_out;
    logic [SCORE_W-1:0]      score_inc;
    logic                    line_changed;
    logic [SCORE_W:0]        score_sum;
    logic                    spawn_hit;
    int                      spawn_pos;
    int                      start_pos;
    int                      cand;
    logic [EXP_W-1:0]        spawn_val;
    logic                    any_win, any_empty, any_pair;

    always_comb begin
        move_vec = {bus.mov_up, bus.mov_down, bus.mov_left, bus.mov_right};
        move_one = $onehot(move_vec);
        move_dir = DIR_LEFT;
        if (bus.mov_up)         move_dir = DIR_UP;
        else if (bus.mov_down)  move_dir = DIR_DOWN;
        else if (bus.mov_right) move_dir = DIR_RIGHT;
    end

    // Element 0 of the extracted line always sits on the side the tiles slide toward
    always_comb begin
        line_in = '0;
        for (int k = 0; k < GRID_N; k++) begin
            case (dir_q)
                DIR_LEFT:  pos[k] = cell_idx(int'(line_q), k, GRID_N);
                DIR_RIGHT: pos[k] = cell_idx(int'(line_q), GRID_N - 1 - k, GRID_N);
                DIR_UP:    pos[k] = cell_idx(k, int'(line_q), GRID_N);
                default:   pos[k] = cell_idx(GRID_N - 1 - k, int'(line_q), GRID_N);
            endcase
            line_in[k*EXP_W +: EXP_W] = grid_q[pos[k]*EXP_W +: EXP_W];
        end
    end

    line_merge #(
        .GRID_N  (GRID_N),
        .EXP_W   (EXP_W),
        .SCORE_W (SCORE_W)
    ) u_merge (
        .line_in   (line_in),
        .line_out  (line_out),
        .score_inc (score_inc),
        .changed   (line_changed)
    );

    assign score_sum = {1'b0, score_q} + {1'b0, score_inc};

    always_comb begin
        spawn_hit = 1'b0;
        spawn_pos = 0;
        cand      = 0;
        start_pos = int'(lfsr_q[7:0]) % NN;
        for (int j = 0; j < NN; j++) begin
            cand = start_pos + j;
            if (cand >= NN) cand = cand - NN;
            if (!spawn_hit && grid_q[cand*EXP_W +: EXP_W] == '0) begin
                spawn_hit = 1'b1;
                spawn_pos = cand;
            end
        end
        spawn_val = (lfsr_q[11:8] == 4'd0) ? EXP_W'(2) : EXP_W'(1);
    end

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < NN; i++) begin
            if (grid_q[i*EXP_W +: EXP_W] >= WIN_THR) any_win = 1'b1;
            if (grid_q[i*EXP_W +: EXP_W] == '0)      any_empty = 1'b1;
        end
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N - 1; c++) begin
                if (grid_q[cell_idx(r, c, GRID_N)*EXP_W +: EXP_W] ==
                    grid_q[cell_idx(r, c + 1, GRID_N)*EXP_W +: EXP_W]) any_pair = 1'b1;
                if (grid_q[cell_idx(c, r, GRID_N)*EXP_W +: EXP_W] ==
                    grid_q[cell_idx(c + 1, r, GRID_N)*EXP_W +: EXP_W]) any_pair = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        score_d   = score_q;
        changed_d = changed_q;
        dir_d     = dir_q;
        line_d    = line_q;
        case (state_q)
            S_INIT, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    grid_d  = '0;
                    score_d = '0;
                    state_d = S_SPAWN0;
                end
            end
            S_SPAWN0, S_SPAWN1: begin
                if (spawn_hit) grid_d[spawn_pos*EXP_W +: EXP_W] = spawn_val;
                state_d = (state_q == S_SPAWN0) ? S_SPAWN1 : S_PLAY;
            end
            S_PLAY: begin
                if (bus.load_en) begin
                    grid_d  = bus.load_grid;
                    state_d = S_CHECK;
                end else if (move_one) begin
                    dir_d     = move_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int k = 0; k < GRID_N; k++) begin
                    grid_d[pos[k]*EXP_W +: EXP_W] = line_out[k*EXP_W +: EXP_W];
                end
                score_d   = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                changed_d = changed_q | line_changed;
                line_d    = line_q + 1'b1;
                if (line_q == LAST_LINE) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                if (!changed_q) begin
                    state_d = S_PLAY;
                end else begin
                    if (spawn_hit) grid_d[spawn_pos*EXP_W +: EXP_W] = spawn_val;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (any_win)                     state_d = S_WIN;
                else if (!any_empty && !any_pair) state_d = S_LOSE;
                else                              state_d = S_PLAY;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_INIT;
            grid_q    <= '0;
            score_q   <= '0;
            changed_q <= 1'b0;
            dir_q     <= DIR_LEFT;
            line_q    <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            score_q   <= score_d;
            changed_q <= changed_d;
            dir_q     <= dir_d;
            line_q    <= line_d;
            lfsr_q    <= lfsr_next(lfsr_q);
        end
    end

    assign bus.grid  = grid_q;
    assign bus.score = score_q;
    assign bus.busy  = !(state_q inside {S_PLAY, S_INIT, S_WIN, S_LOSE});
    assign bus.win   = (state_q == S_WIN);
    assign bus.lose  = (state_q == S_LOSE);

endmodule
